// File: rtl/frv_wb_arb.sv
// Two-master Wishbone classic arbiter: FazyRV imem/dmem onto one slave bus.
// Optional slave-ack timeout enabled by defining FRV_WB_ARB_TIMEOUT_EN.
module frv_wb_arb #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        m_i_cyc_i,
    input  logic        m_i_stb_i,
    input  logic [31:0] m_i_adr_i,
    output logic [31:0] m_i_dat_o,
    output logic        m_i_ack_o,
    input  logic        m_d_cyc_i,
    input  logic        m_d_stb_i,
    input  logic        m_d_we_i,
    input  logic [3:0]  m_d_be_i,
    input  logic [31:0] m_d_adr_i,
    input  logic [31:0] m_d_dat_i,
    output logic [31:0] m_d_dat_o,
    output logic        m_d_ack_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic        timeout_o,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2
    } state_t;

    state_t state;
    logic   last_d;
    logic   req_i;
    logic   req_d;
    logic   gi;
    logic   gd;
    logic   tmo;

    assign req_i = m_i_cyc_i & m_i_stb_i;
    assign req_d = m_d_cyc_i & m_d_stb_i;
    assign gi    = (state == BUS_I);
    assign gd    = (state == BUS_D);

`ifdef FRV_WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYC);

    logic [7:0] cnt;
    logic       cur_req;

    assign cur_req = gi ? req_i : req_d;
    // A real ack in the limit cycle wins over the timeout.
    assign tmo = (gi | gd) & cur_req & ~s_ack_i & (cnt == TMO_LIM);

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt <= 8'd0;
        end else if (state == IDLE) begin
            cnt <= 8'd0;
        end else if (!s_ack_i) begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYC == 0);
    assign tmo        = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_i && (!req_d || last_d)) begin
                        state  <= BUS_I;
                        last_d <= 1'b0;
                    end else if (req_d) begin
                        state  <= BUS_D;
                        last_d <= 1'b1;
                    end
                end
                BUS_I: begin
                    if (s_ack_i || !req_i || tmo) state <= IDLE;
                end
                BUS_D: begin
                    if (s_ack_i || !req_d || tmo) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_be_o  = 4'h0;
        s_adr_o = 32'h0;
        s_dat_o = 32'h0;
        if (gi) begin
            s_cyc_o = req_i & ~tmo;
            s_stb_o = req_i & ~tmo;
            s_be_o  = 4'hF;
            s_adr_o = m_i_adr_i;
        end else if (gd) begin
            s_cyc_o = req_d & ~tmo;
            s_stb_o = req_d & ~tmo;
            s_we_o  = m_d_we_i;
            s_be_o  = m_d_be_i;
            s_adr_o = m_d_adr_i;
            s_dat_o = m_d_dat_i;
        end
    end

    assign m_i_ack_o = gi & (s_ack_i | tmo);
    assign m_d_ack_o = gd & (s_ack_i | tmo);
    assign m_i_dat_o = (gi & tmo) ? 32'h0 : s_dat_i;
    assign m_d_dat_o = (gd & tmo) ? 32'h0 : s_dat_i;
    assign timeout_o = tmo;
    assign gnt_o     = {gd, gi};

endmodule
